nn_layer_sequencer: RTL

//  Controller for the 4-neuron perceptron layer. Accepts one byte stream (valid/ready) and splits it:
//  24 parameter bytes go to the parameter register file, then 4 input bytes go to the input register.
//  It then waits for the combinational layer to settle and can feed the outputs back as inputs for

---
 rtl/nn_layer_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/nn_layer_sequencer.sv
// Sequences one valid/ready byte stream into the layer's parameter file and input register, then settles and recurs.
// Latency: done at 5+SETTLE_CYC+passes*(1+SETTLE_CYC) cycles after start (+24 with params); cfg_ready only in load states.
// Backpressure: gaps in cfg_valid stall the load states; abort drops cfg_ready so nothing is accepted that cycle.
module nn_layer_sequencer #(
    parameter int N_NEURONS  = 4,
    parameter int N_PARAMS   = 6,
    parameter int DATA_W     = 8,
    parameter int SETTLE_CYC = 1,
    localparam int ADDR_W    = $clog2(N_NEURONS * N_PARAMS),
    localparam int SEL_W     = $clog2(N_NEURONS)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          load_params,
    input  logic [1:0]                    num_passes,
    input  logic                          cfg_valid,
    input  logic [DATA_W-1:0]             cfg_data,
    output logic                          cfg_ready,
    output logic                          param_we,
    output logic [ADDR_W-1:0]             param_addr,
    output logic [DATA_W-1:0]             param_wdata,
    output logic                          in_we,
    output logic [SEL_W-1:0]              in_sel,
    output logic [DATA_W-1:0]             in_wdata,
    output logic                          feedback_en,
    input  logic [N_NEURONS*DATA_W-1:0]   neuron_out,
    output logic [N_NEURONS*DATA_W-1:0]   result,
    output logic                          result_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_PARAM,
        S_LOAD_INPUT,
        S_SETTLE,
        S_FEEDBACK,
        S_DONE
    } state_t;

    state_t                        r_state;
    logic [ADDR_W-1:0]             r_byte_cnt;
    logic [1:0]                    r_passes;
    logic [1:0]                    r_pass_cnt;
    logic [SET_W-1:0]              r_settle_cnt;
    logic [N_NEURONS*DATA_W-1:0]   r_result;
    logic                          r_result_valid;

    logic w_loading;
    logic w_accept;
    logic w_last_param;
    logic w_last_input;
    logic w_settled;

    // abort wins over the handshake, so ready is withdrawn in that cycle
    assign w_loading    = (r_state == S_LOAD_PARAM) || (r_state == S_LOAD_INPUT);
    assign cfg_ready    = w_loading & ~abort;
    assign w_accept     = cfg_valid & cfg_ready;
    assign w_last_param = (r_byte_cnt == ADDR_W'(N_NEURONS * N_PARAMS - 1));
    assign w_last_input = (r_byte_cnt == ADDR_W'(N_NEURONS - 1));
    assign w_settled    = (r_settle_cnt == SET_W'(SETTLE_CYC - 1));

    assign param_we     = w_accept && (r_state == S_LOAD_PARAM);
    assign param_addr   = r_byte_cnt;
    assign param_wdata  = cfg_data;
    assign in_we        = w_accept && (r_state == S_LOAD_INPUT);
    assign in_sel       = r_byte_cnt[SEL_W-1:0];
    assign in_wdata     = cfg_data;
    assign feedback_en  = (r_state == S_FEEDBACK);
    assign done         = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign result       = r_result;
    assign result_valid = r_result_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_byte_cnt     <= '0;
            r_passes       <= '0;
            r_pass_cnt     <= '0;
            r_settle_cnt   <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else if (abort) begin
            r_state        <= S_IDLE;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_passes       <= num_passes;
                        r_byte_cnt     <= '0;
                        r_pass_cnt     <= '0;
                        r_result_valid <= 1'b0;
                        r_state        <= load_params ? S_LOAD_PARAM : S_LOAD_INPUT;
                    end
                end
                S_LOAD_PARAM: begin
                    if (w_accept) begin
                        if (w_last_param) begin
                            r_byte_cnt <= '0;
                            r_state    <= S_LOAD_INPUT;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + ADDR_W'(1);
                        end
                    end
                end
                S_LOAD_INPUT: begin
                    if (w_accept) begin
                        if (w_last_input) begin
                            r_byte_cnt   <= '0;
                            r_settle_cnt <= '0;
                            r_state      <= S_SETTLE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + ADDR_W'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    // the last settle cycle is when neuron_out is trusted
                    if (w_settled) begin
                        if (r_pass_cnt == r_passes) begin
                            r_result       <= neuron_out;
                            r_result_valid <= 1'b1;
                            r_state        <= S_DONE;
                        end else begin
                            r_state <= S_FEEDBACK;
                        end
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SET_W'(1);
                    end
                end
                S_FEEDBACK: begin
                    r_pass_cnt   <= r_pass_cnt + 2'd1;
                    r_settle_cnt <= '0;
                    r_state      <= S_SETTLE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
